// File: rtl/noc_strm_pkg.sv
// Shared constants and types for the NOC <-> word-stream bridge.
package noc_strm_pkg;

  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_RESULT = 2'b10;
  localparam int         F_BIT     = 5;
  localparam int         CNT_MSB   = 4;
  localparam int         MAX_DW    = 256;

  function automatic int BPW(input int dw);
    return dw / 8;
  endfunction

  // Sized for the widest supported word; narrower builds zero-extend.
  typedef struct packed {
    logic              first;
    logic [MAX_DW-1:0] data;
  } fifo_entry_t;

  typedef enum logic {
    ASM_IDLE,
    ASM_COLLECT
  } asm_state_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_HDR,
    SER_DATA
  } ser_state_t;

endpackage

// File: rtl/noc_strm_bridge_sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head read.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot, so writes into a full FIFO are fine then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/noc_strm_bridge.sv
// Byte-serial NOC link to DW-bit word streams (inbound assembler) and back (outbound serialiser).
module noc_strm_bridge
  import noc_strm_pkg::*;
#(
  parameter int DW        = 64,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          noc_to_dev_ctl,
  input  logic [7:0]    noc_to_dev_data,
  output logic          noc_from_dev_ctl,
  output logic [7:0]    noc_from_dev_data,
  output logic          pushin,
  output logic          firstin,
  input  logic          stopin,
  output logic [DW-1:0] din,
  input  logic          pushout,
  input  logic          firstout,
  output logic          stopout,
  input  logic [DW-1:0] dout,
  output logic [1:0]    err
);

  localparam int             NB     = BPW(DW);
  localparam int             BW     = $clog2(NB);
  localparam int             IAW    = $clog2(IN_DEPTH) + 1;
  localparam int             OAW    = $clog2(OUT_DEPTH) + 1;
  localparam logic [BW-1:0]  LAST_B = BW'(NB - 1);

  // ---- inbound assembler (p0: byte capture) ----
  asm_state_t    asm_q, asm_d;
  logic          is_hdr, is_write, start, take_byte, trunc, word_done;
  logic          byte_last, word_last;
  logic [BW-1:0] byte_idx;
  logic [4:0]    word_idx, n_last;
  logic          f_q;
  logic [DW-1:0] asm_word, asm_next;

  assign is_hdr    = noc_to_dev_ctl;
  assign is_write  = is_hdr && (noc_to_dev_data[7:6] == OP_WRITE);
  assign byte_last = (byte_idx == LAST_B);
  assign word_last = (word_idx == n_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) asm_q <= ASM_IDLE;
    else       asm_q <= asm_d;
  end

  always_comb begin
    asm_d = asm_q;
    case (asm_q)
      ASM_IDLE:    if (is_write) asm_d = ASM_COLLECT;
      ASM_COLLECT: begin
        if (is_hdr)                      asm_d = is_write ? ASM_COLLECT : ASM_IDLE;
        else if (byte_last && word_last) asm_d = ASM_IDLE;
      end
      default:     asm_d = ASM_IDLE;
    endcase
  end

  always_comb begin
    start     = is_write;
    take_byte = (asm_q == ASM_COLLECT) && !is_hdr;
    trunc     = (asm_q == ASM_COLLECT) && is_hdr;
    word_done = take_byte && byte_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      word_idx <= '0;
      n_last   <= '0;
      f_q      <= 1'b0;
    end else if (start) begin
      byte_idx <= '0;
      word_idx <= '0;
      n_last   <= noc_to_dev_data[CNT_MSB:0];
      f_q      <= noc_to_dev_data[F_BIT];
    end else if (take_byte) begin
      byte_idx <= byte_last ? '0 : byte_idx + 1'b1;
      if (byte_last) word_idx <= word_idx + 1'b1;
    end
  end

  // A restart simply overwrites every byte lane, so a partial word needs no clearing.
  always_comb begin
    asm_next = asm_word;
    asm_next[{byte_idx, 3'b000} +: 8] = noc_to_dev_data;
  end

  always_ff @(posedge clk) begin
    if (take_byte) asm_word <= asm_next;
  end

  // ---- p1: completed word staged for the inbound FIFO ----
  logic          vld_p1;
  logic [DW-1:0] word_p1;
  logic          first_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= word_done;
  end

  always_ff @(posedge clk) begin
    if (word_done) begin
      word_p1  <= asm_next;
      first_p1 <= f_q && (word_idx == '0);
    end
  end

  logic          in_full, in_empty, in_drop;
  logic [DW:0]   in_q;
  logic [IAW-1:0] in_count_unused;
  fifo_entry_t   in_head;

  sync_fifo #(.W(DW + 1), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (vld_p1),
    .wdata ({first_p1, word_p1}),
    .pop   (pushin),
    .head  (in_q),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count_unused)
  );

  assign in_drop = vld_p1 && in_full && !pushin;
  assign in_head = '{first: in_q[DW], data: MAX_DW'(in_q[DW-1:0])};
  assign pushin  = !in_empty && !stopin;
  assign firstin = !in_empty && in_head.first;
  assign din     = in_empty ? '0 : in_head.data[DW-1:0];

  // ---- outbound FIFO and serialiser ----
  logic           out_accept, out_pop, out_empty, out_full_unused;
  logic [OAW-1:0] out_count;
  logic [DW:0]    out_q;
  fifo_entry_t    out_head;
  logic [DW-1:0]  out_word;
  logic [7:0]     hdr_byte;
  ser_state_t     ser_q, ser_d;
  logic [BW-1:0]  ser_idx;

  assign out_accept = pushout && !stopout;

  sync_fifo #(.W(DW + 1), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (out_accept),
    .wdata ({firstout, dout}),
    .pop   (out_pop),
    .head  (out_q),
    .full  (out_full_unused),
    .empty (out_empty),
    .count (out_count)
  );

  assign out_head = '{first: out_q[DW], data: MAX_DW'(out_q[DW-1:0])};
  assign out_word = out_head.data[DW-1:0];
  assign hdr_byte = {OP_RESULT, out_head.first, 5'd0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ser_q <= SER_IDLE;
    else       ser_q <= ser_d;
  end

  always_comb begin
    ser_d = ser_q;
    case (ser_q)
      SER_IDLE: if (!out_empty) ser_d = SER_DATA;
      SER_HDR:  ser_d = SER_DATA;
      SER_DATA: begin
        if (ser_idx == LAST_B)
          ser_d = ((out_count > OAW'(1)) || out_accept) ? SER_HDR : SER_IDLE;
      end
      default:  ser_d = SER_IDLE;
    endcase
  end

  always_comb begin
    noc_from_dev_ctl  = 1'b0;
    noc_from_dev_data = 8'h00;
    out_pop           = 1'b0;
    case (ser_q)
      SER_IDLE: begin
        if (!out_empty) begin
          noc_from_dev_ctl  = 1'b1;
          noc_from_dev_data = hdr_byte;
        end
      end
      SER_HDR: begin
        noc_from_dev_ctl  = 1'b1;
        noc_from_dev_data = hdr_byte;
      end
      SER_DATA: begin
        noc_from_dev_data = out_word[{ser_idx, 3'b000} +: 8];
        out_pop           = (ser_idx == LAST_B);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  ser_idx <= '0;
    else if (ser_q == SER_DATA) ser_idx <= (ser_idx == LAST_B) ? '0 : ser_idx + 1'b1;
    else                        ser_idx <= '0;
  end

  // Registered full flag that anticipates the accept filling the last slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stopout <= 1'b0;
    else       stopout <= ((out_count == OAW'(OUT_DEPTH)) && !out_pop) ||
                          ((out_count == OAW'(OUT_DEPTH - 1)) && out_accept && !out_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 2'b00;
    else begin
      if (trunc || in_drop)    err[0] <= 1'b1;
      if (pushout && stopout)  err[1] <= 1'b1;
    end
  end

  if (DW < MAX_DW) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^{in_head.data[MAX_DW-1:DW], out_head.data[MAX_DW-1:DW]};
  end

endmodule

// File: doc/noc_strm_bridge.md
Name: noc_strm_bridge

Overview:
Parametrised successor to the fixed 8-bit/64-bit NOC interface. It converts the byte-serial NOC link into DW-bit word streams toward a device (push/stop/first) and serialises device result words back onto the NOC. It adds configurable word width, inbound/outbound FIFO depths, multi-word packets and sticky error reporting, and sits between the NOC and a perm-class device inside a box.

Parameters:
DW, 64, stream word width in bits; multiple of 8, range 16..256
IN_DEPTH, 4, inbound word FIFO entries (power of 2, >=2)
OUT_DEPTH, 4, outbound word FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
noc_to_dev_ctl  in  1  1 = header byte, 0 = payload byte
noc_to_dev_data  in  8  NOC byte toward device
noc_from_dev_ctl  out  1  1 = header byte toward NOC
noc_from_dev_data  out  8  byte toward NOC
pushin  out  1  inbound word valid to device
firstin  out  1  word is first of packet
stopin  in  1  device back-pressure; no pop while high
din  out  DW  inbound word
pushout  in  1  device result word valid
firstout  in  1  result word is first of packet
stopout  out  1  bridge full; device must not push
dout  in  DW  result word
err  out  2  sticky: [0] inbound overflow/truncation, [1] push while stopout

Behaviour:
- Reset (async): FIFOs empty, assembler idle, pushin=0, firstin=0, din=0, stopout=0, noc_from_dev_ctl=0, noc_from_dev_data=0, err=0.
- Inbound header (ctl=1): bits[7:6]=2'b01 WRITE, else NOP (ignored). bit[5]=F. bits[4:0]=N-1, giving N words (1..32).
- After a WRITE header, N*DW/8 payload bytes follow (ctl=0), LSB first: byte k of a word lands in bits [8k+7:8k]. Payload bytes with no open packet are ignored.
- Assembler states: IDLE -> COLLECT on a WRITE header. In COLLECT, byte and word counters advance. A completed word is written to the inbound FIFO in the cycle after its last byte, tagged first=F for word 0 only. After the last byte of word N-1, return to IDLE.
- Header during COLLECT: discard the partial word, set err[0], then process the new header in the same cycle.
- Completed word while inbound FIFO full: drop the word, set err[0], continue collecting.
- Inbound pop: pushin = !empty && !stopin. din/firstin are driven from the FIFO head (combinational read of the registered array). A word is consumed on a cycle where pushin=1. Write and pop in the same cycle are allowed at any occupancy, including full.
- Outbound: a word is accepted when pushout=1 and stopout=0. stopout = registered (count==OUT_DEPTH), or (count==OUT_DEPTH-1 and an accept with no concurrent pop). pushout while stopout=1 discards the word and sets err[1].
- Serialiser states: IDLE, HDR, DATA.
  - IDLE with FIFO non-empty: emit header {2'b10, first, 5'd0} with ctl=1, enter DATA.
  - DATA emits DW/8 bytes, LSB first, ctl=0, one per cycle. The word pops on the last byte.
  - If the FIFO is non-empty on the last byte, the next header follows on the next cycle with no gap.
  - When idle, outputs are ctl=0, data=8'h00.
- Latency: inbound last payload byte -> pushin high is 2 cycles (stopin=0, FIFO was empty). Outbound accept -> header on NOC is 1 cycle.
- err bits clear only on reset. Reset mid-packet drops all state; nothing is resumed.

Decomposition:
- Package noc_strm_pkg holds:
  - header field constants: OP_WRITE=2'b01, OP_RESULT=2'b10, F bit index 5, count field [4:0]
  - localparam function BPW(DW)=DW/8
  - typedef of the FIFO entry struct {first, data}.
- One sub-module, sync_fifo (params W, DEPTH; push/pop/full/empty/count), instantiated twice: inbound and outbound.

Test Plan:
- DW=64. Send header 8'h60 (WRITE, F=1, N=1), then bytes 01..08. Expect pushin with din=64'h0807060504030201, firstin=1, 2 cycles after byte 08.
- Send header 8'h41 (N=2, F=0) plus 16 bytes with stopin=1 for 20 cycles. Expect both words held, pushin=0. Release stopin: two consecutive pushin, firstin=0 on both.
- Send 5 single-word packets with stopin=1, IN_DEPTH=4. Expect the 5th word dropped, err=2'b01, the first 4 words delivered intact afterwards.
- Device pushes dout=64'hA5A5..A5 with firstout=1. Expect ctl=1 data=8'hA0, then 8 bytes 8'hA5 with ctl=0, then idle 0/0.
- Push 5 words back-to-back, OUT_DEPTH=4. Expect stopout high after the 4th accept and the 5th push to set err[1]. Expect NOC output of 4 gapless 9-byte packets (36 cycles).
- Send header 8'h60, 3 payload bytes, then header 8'h60 and 8 bytes. Expect one word from the second packet only and err[0]=1. Assert reset mid-payload: all outputs return to zero immediately.
